// File: rtl/tile_video_core.sv
// tile_video_core: tile-mode VGA core with scrolling, attribute/tile/palette fetch and raster IRQ
module tile_video_core #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CH_BITS  = 3,
  parameter int MAP_LOG2 = 6
) (
  input  logic                    CLK100MHz,
  input  logic                    rst,
  input  logic [MAP_LOG2+2:0]     scroll_x,
  input  logic [MAP_LOG2+2:0]     scroll_y,
  input  logic [9:0]              irq_line,
  input  logic                    irq_enable,
  input  logic                    irq_ack,
  output logic                    attr_re,
  output logic [2*MAP_LOG2-1:0]   attr_addr,
  input  logic [15:0]             attr_data,
  output logic                    tile_re,
  output logic [10:0]             tile_addr,
  input  logic [7:0]              tile_data,
  output logic                    pal_re,
  output logic [3:0]              pal_addr,
  input  logic [3*CH_BITS-1:0]    pal_data,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic [CH_BITS-1:0]      vga_r,
  output logic [CH_BITS-1:0]      vga_g,
  output logic [CH_BITS-1:0]      vga_b,
  output logic                    irq,
  output logic                    frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW = $clog2(PIX_DIV);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = MAP_LOG2 + 3;
  localparam logic [PW-1:0] P_LAST = PW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  logic [PW-1:0]          phase;
  logic [HW-1:0]          h;
  logic [VW-1:0]          v;
  logic [XW-1:0]          sx, sy, xe, ye;
  logic [3:0]             fg, bg;
  logic [3*CH_BITS-1:0]   pix;
  logic                   pending, act, p0;
  assign act = h < H_ACT && v < V_ACT;
  assign p0 = phase == '0;
  assign xe = XW'(h) + sx;
  assign ye = XW'(v) + sy;
  // Read ports are combinational from the counters so each memory answers within the same pixel period
  assign attr_re = !rst && act && p0;
  assign tile_re = !rst && act && phase == PW'(1);
  assign pal_re = !rst && act && phase == PW'(2);
  assign attr_addr = attr_re ? {ye[XW-1:3], xe[XW-1:3]} : '0;
  assign tile_addr = tile_re ? {attr_data[7:0], ye[2:0]} : '0;
  assign pal_addr = pal_re ? (tile_data[~xe[2:0]] ? fg : bg) : '0;
  assign frame_start = !rst && p0 && h == '0 && v == '0;
  assign irq = pending && irq_enable;
  always_ff @(posedge CLK100MHz) begin
    if (rst) begin
      phase <= '0;
      h <= '0;
      v <= '0;
      sx <= '0;
      sy <= '0;
      fg <= '0;
      bg <= '0;
      pix <= '0;
      pending <= 1'b0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      {vga_b, vga_g, vga_r} <= '0;
    end else begin
      phase <= phase == P_LAST ? '0 : phase + PW'(1);
      // Pins take the pixel fetched during this period, so colour and syncs share one period of delay
      if (phase == P_LAST) begin
        h <= h == H_LAST ? '0 : h + HW'(1);
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + VW'(1);
        vga_hs <= !(h >= H_SS && h < H_SE);
        vga_vs <= !(v >= V_SS && v < V_SE);
        {vga_b, vga_g, vga_r} <= act ? (phase == PW'(3) ? pal_data : pix) : '0;
      end
      if (phase == PW'(1)) {bg, fg} <= attr_data[15:8];
      if (phase == PW'(3)) pix <= pal_data;
      if (p0 && h == '0 && v == V_ACT) begin
        sx <= scroll_x;
        sy <= scroll_y;
      end
      if (p0 && h == H_ACT && 32'(v) == 32'(irq_line)) pending <= 1'b1;
      else if (irq_ack) pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tile_video_core.sv
// tb_tile_video_core: scoreboard plus table-driven frames and directed corner cases on a reduced raster
module tb_tile_video_core;
  localparam int PD = 4, HA = 16, HF = 2, HS = 3, HB = 3, VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = PD * HT * VT, LIM = 2 * FRAME;
  logic clk = 0, rst = 1;
  logic [8:0] scroll_x = '0, scroll_y = '0;
  logic [9:0] irq_line = 10'd600;
  logic irq_enable = 0, irq_ack = 0;
  logic attr_re, tile_re, pal_re, vga_hs, vga_vs, irq, frame_start;
  logic [11:0] attr_addr;
  logic [10:0] tile_addr;
  logic [3:0] pal_addr;
  logic [15:0] attr_data = '0;
  logic [7:0] tile_data = '0;
  logic [8:0] pal_data = '0;
  logic [2:0] vga_r, vga_g, vga_b;
  logic [15:0] attr_mem [4096];
  logic [7:0] tile_mem [2048];
  logic [8:0] pal_mem [16];
  int bph = 0, bh = 0, bv = 0;
  int checks = 0, errors = 0;
  logic [8:0] sx_m = '0, sy_m = '0;
  logic pend_m = 0;
  logic [10:0] q [$];
  logic [10:0] cur;
  typedef struct { logic [8:0] sx, sy; logic [9:0] line; logic en; int rises; } vec_t;
  vec_t tbl [6];

  tile_video_core #(.PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CH_BITS(3), .MAP_LOG2(6)) dut (
    .CLK100MHz(clk), .rst(rst), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .irq_line(irq_line), .irq_enable(irq_enable), .irq_ack(irq_ack),
    .attr_re(attr_re), .attr_addr(attr_addr), .attr_data(attr_data),
    .tile_re(tile_re), .tile_addr(tile_addr), .tile_data(tile_data),
    .pal_re(pal_re), .pal_addr(pal_addr), .pal_data(pal_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .irq(irq), .frame_start(frame_start));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (attr_re) attr_data <= attr_mem[attr_addr];
    if (tile_re) tile_data <= tile_mem[tile_addr];
    if (pal_re) pal_data <= pal_mem[pal_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      bph <= 0; bh <= 0; bv <= 0;
    end else begin
      bph <= bph == PD - 1 ? 0 : bph + 1;
      if (bph == PD - 1) begin
        bh <= bh == HT - 1 ? 0 : bh + 1;
        if (bh == HT - 1) bv <= bv == VT - 1 ? 0 : bv + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (pixel %0d,%0d phase %0d)", name, got, want, bh, bv, bph);
    end
  endtask

  function automatic logic [10:0] exp_pix(input int h, input int v);
    int xe, ye;
    logic [15:0] a;
    logic [7:0] t;
    logic [8:0] c;
    xe = (h + int'(sx_m)) % 512;
    ye = (v + int'(sy_m)) % 512;
    a = attr_mem[(ye / 8) * 64 + xe / 8];
    t = tile_mem[int'(a[7:0]) * 8 + ye % 8];
    c = pal_mem[t[7 - xe % 8] ? a[11:8] : a[15:12]];
    return {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
            (h < HA && v < VA) ? c : 9'd0};
  endfunction

  // Reference model sampled mid-cycle: pins, read enables, frame_start and irq on every clock
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      q.push_back(11'h600);
      pend_m = 0; sx_m = '0; sy_m = '0;
    end else begin
      if (bph == 0) begin
        cur = q.pop_front();
        q.push_back(exp_pix(bh, bv));
        if (bh == 0 && bv == VA) begin sx_m = scroll_x; sy_m = scroll_y; end
      end
      chk("pins", 64'({vga_hs, vga_vs, vga_b, vga_g, vga_r}), 64'(cur));
      chk("read_en", 64'({attr_re, tile_re, pal_re}),
          64'({bh < HA && bv < VA && bph == 0, bh < HA && bv < VA && bph == 1, bh < HA && bv < VA && bph == 2}));
      chk("frame_start", 64'(frame_start), 64'(bph == 0 && bh == 0 && bv == 0));
      chk("irq", 64'(irq), 64'(pend_m & irq_enable));
      if (bph == 0 && bh == HA && bv == int'(irq_line)) pend_m = 1;
      else if (irq_ack) pend_m = 0;
    end
  end

  task automatic wait_pix(input int ph, input int h, input int v);
    int n = 0;
    @(posedge clk); #1;
    while (!(bph == ph && bh == h && bv == v) && n < LIM) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIM) chk("wait_timeout", 64'(n), 64'(0));
  endtask

  task automatic chk_reset_vals();
    chk("reset_vals", 64'({vga_hs, vga_vs, vga_r, vga_g, vga_b, irq, frame_start, attr_re, tile_re, pal_re,
        attr_addr, tile_addr, pal_addr}), 64'({2'b11, 41'd0}));
  endtask

  initial begin
    int hs_lo, vs_lo, rises;
    logic prev;
    tbl[0] = '{sx: 9'd0,   sy: 9'd0,   line: 10'd5,   en: 1'b1, rises: 1};
    tbl[1] = '{sx: 9'd3,   sy: 9'd0,   line: 10'd12,  en: 1'b1, rises: 1};
    tbl[2] = '{sx: 9'd511, sy: 9'd5,   line: 10'd16,  en: 1'b1, rises: 1};
    tbl[3] = '{sx: 9'd100, sy: 9'd300, line: 10'd7,   en: 1'b0, rises: 0};
    tbl[4] = '{sx: 9'd7,   sy: 9'd511, line: 10'd600, en: 1'b1, rises: 0};
    tbl[5] = '{sx: 9'd0,   sy: 9'd0,   line: 10'd17,  en: 1'b1, rises: 0};
    foreach (attr_mem[i]) attr_mem[i] = 16'($urandom);
    foreach (tile_mem[i]) tile_mem[i] = 8'($urandom);
    foreach (pal_mem[i]) pal_mem[i] = 9'($urandom);
    attr_mem[0] = 16'h2105;
    tile_mem[40] = 8'h80;
    pal_mem[1] = 9'h1FF;
    pal_mem[2] = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 0;
    // Tile 5 row 0 = 0x80: only the leftmost pixel takes fg (white)
    for (int k = 0; k < 8; k++) begin
      wait_pix(0, k + 1, 0);
      @(negedge clk);
      chk("tile_row_px", 64'({vga_b, vga_g, vga_r}), k == 0 ? 64'h1FF : 64'h0);
    end
    // Scroll written mid-frame is only picked up at the latch line
    wait_pix(0, 0, 2);
    scroll_x = 9'd3;
    wait_pix(0, 1, 3);
    @(negedge clk);
    chk("scroll_held", 64'({vga_b, vga_g, vga_r}), 64'(exp_pix(0, 3) & 11'h1FF));
    wait_pix(0, 0, 13);
    tile_mem[40] = 8'h90;
    wait_pix(0, 1, 0);
    @(negedge clk);
    chk("scroll3_px0", 64'({vga_b, vga_g, vga_r}), 64'h1FF);
    wait_pix(0, 0, 2);
    scroll_x = 9'd511;
    wait_pix(0, 0, 0);
    wait_pix(0, 2, 0);
    @(negedge clk);
    chk("scroll511_px1", 64'({vga_b, vga_g, vga_r}), 64'h1FF);
    for (int i = 0; i < 6; i++) begin
      wait_pix(0, 0, 0);
      scroll_x = tbl[i].sx;
      scroll_y = tbl[i].sy;
      irq_line = tbl[i].line;
      irq_enable = tbl[i].en;
      irq_ack = 1;
      @(posedge clk); #1;
      irq_ack = 0;
      hs_lo = 0; vs_lo = 0; rises = 0; prev = 0;
      repeat (FRAME - 2) begin
        @(negedge clk);
        hs_lo += int'(!vga_hs);
        vs_lo += int'(!vga_vs);
        rises += int'(irq && !prev);
        prev = irq;
      end
      chk("hs_low_clocks", 64'(hs_lo), 64'(VT * HS * PD));
      chk("vs_low_clocks", 64'(vs_lo), 64'(VS * HT * PD));
      chk("irq_rises", 64'(rises), 64'(tbl[i].rises));
    end
    wait_pix(0, 0, 2);
    irq_line = 10'd4;
    irq_enable = 1;
    irq_ack = 1;
    @(posedge clk); #1;
    irq_ack = 0;
    chk("ack_clears", 64'(irq), 64'(0));
    wait_pix(0, HA, 4);
    irq_ack = 1;
    @(posedge clk); #1;
    irq_ack = 0;
    chk("set_beats_ack", 64'(irq), 64'(1));
    wait_pix(0, 0, 6);
    irq_ack = 1;
    @(posedge clk); #1;
    irq_ack = 0;
    chk("late_ack", 64'(irq), 64'(0));
    wait_pix(1, 10, 3);
    rst = 1;
    @(posedge clk); #1;
    chk_reset_vals();
    rst = 0;
    @(negedge clk);
    chk("fs_after_rst", 64'(frame_start), 64'(1));
    wait_pix(0, 0, 16);
    wait_pix(0, 4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
